demux_1xn_stream: RTL and testbench
===================================

Name: demux_1xn_stream

Overview:
- Parametrised 1-to-N packet demultiplexer with a valid/ready handshake on every port.
- A single input stream is steered to one of N output channels by a select value sampled on the first beat of each packet; the channel stays locked until the last beat.
- Each output has a one-entry register slot, so outputs are registered with one cycle of latency and full throughput.
- Sits between a packet source and N consumers. It is the streaming generalisation of the combinational 1x2 demux.

Parameters:
- WIDTH, 8: data width in bits.
- N, 4: number of output channels, N >= 2.
- SELW, $clog2(N): select width. Derived; do not override.

Ports:
- clk  in  1  system clock. Rising edge only.
- rst  in  1  synchronous, active-high reset. This is the single clock domain.
- in_data  in  WIDTH  input beat data.
- in_valid  in  1  input beat valid.
- in_last  in  1  marks the final beat of a packet.
- in_sel  in  SELW  destination channel. Sampled only on the first beat of a packet.
- in_ready  out  1  input can accept a beat this cycle.
- out_data  out  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- out_valid  out  N  per-channel valid.
- out_last  out  N  per-channel last.
- out_ready  in  N  per-channel downstream ready.
- err_clr  in  1  clears err.
- err  out  1  sticky flag. Set when a packet's first beat has in_sel >= N.

Behaviour:
- Reset: state goes to IDLE. out_valid, out_last, out_data and err all go to 0. in_ready is forced to 0 while rst=1.
- Transfer rules:
  - An input beat is accepted when in_valid && in_ready.
  - An output beat on channel k transfers when out_valid[k] && out_ready[k].
  - in_valid may not depend on in_ready. Once asserted, the source holds data, last and sel stable until the beat is accepted.
- Target channel ch: in_sel when state is IDLE, otherwise the locked channel lock_ch.
- Slot k behaviour:
  - Loads in_data and in_last when a beat is accepted with ch==k. The data is visible on out_data and out_valid[k] the next cycle (1-cycle latency).
  - When slot k drains and is not reloaded in the same cycle, out_valid[k], out_last[k] and its out_data slice all clear to 0.
  - Non-valid channels always drive 0 data.
  - Simultaneous drain and load of the same slot: the load wins, out_valid[k] stays 1 and the new data appears. This gives 1 beat per cycle sustained.
- in_ready (combinational):
  - DROP state: 1.
  - IDLE with in_sel >= N: 1.
  - Otherwise: !out_valid[ch] || out_ready[ch].
  - in_ready never depends on in_valid.
- State machine:
  - IDLE, accepted beat with in_sel < N: if in_last, stay in IDLE. Otherwise go to ROUTE and set lock_ch = in_sel.
  - IDLE, accepted beat with in_sel >= N (only possible when N is not a power of 2): the beat is discarded and err is set. If in_last, stay in IDLE; otherwise go to DROP.
  - ROUTE: beats go to lock_ch and in_sel is ignored. An accepted beat with in_last returns to IDLE.
  - DROP: every beat is discarded and in_sel is ignored. An accepted beat with in_last returns to IDLE.
- Routing independence: while ROUTE targets channel B, an older beat still held in channel A's slot may wait indefinitely. It does not block B.
- err: if err_clr and a new error occur in the same cycle, set wins.
- Reset mid-packet: the packet is abandoned and any beats still in slots are lost. The next accepted beat is treated as a first beat.
- Any out_ready[k] pattern is legal. Data is never duplicated or reordered within a channel.

Decomposition:
- Shared include file (demux_defs.vh) holds the state encodings ST_IDLE=2'd0, ST_ROUTE=2'd1, ST_DROP=2'd2.
- Sub-module demux_out_slot: the one-entry register slot, parameter WIDTH, with ports clk, rst, load, ld_data, ld_last, ready, valid, data, last.
- The top level instantiates N copies of demux_out_slot in a generate loop and holds the FSM plus in_ready logic.

Test Plan:
- Apply rst for 2 cycles, then release. Required: all outputs 0 and in_ready=0 during reset. In the first cycle after release, in_ready=1 and state=IDLE.
- N=4, out_ready=4'b1111, send 3-beat packet sel=2 with data 0xA1,0xA2,0xA3, changing in_sel to 0 on beats 2-3. Required: channel 2 shows A1,A2,A3 on consecutive cycles starting one cycle after acceptance, out_last[2] is set on A3 only, and channels 0, 1 and 3 stay valid=0 with data 0.
- N=4, out_ready[1]=0, send single-beat packets 0x11 to ch1, then 0x22 to ch1, then 0x33 to ch3. Required:
  - 0x11 is held on ch1.
  - in_ready drops while 0x22 targets ch1.
  - Raising out_ready[1] releases 0x11, then 0x22 is accepted.
  - 0x33 passes to ch3 without waiting for ch1 to drain.
- N=3, send 2-beat packet sel=3. Required: both beats accepted with in_ready=1, no out_valid asserted, err=1 and sticky. Then pulse err_clr and check err=0.
- Send 4-beat packet to ch0 and assert rst after beat 2. Required: ch0 slot cleared. A following 1-beat packet sel=1 routes to ch1.
- Stream 16 beats to ch3 with out_ready[3] toggling every cycle. Required: all 16 beats arrive in order with no loss or duplication.

Source files
------------

// File: rtl/demux_1xn_stream_pkg.sv
// rtl/demux_1xn_stream_pkg.sv - shared state type and select helper for the 1xN stream demux
package demux_1xn_stream_pkg;

    `include "demux_defs.vh"

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ROUTE = ST_ROUTE,
        DROP  = ST_DROP
    } demux_state_e;

    function automatic logic sel_in_range(input int sel, input int n);
        return sel < n;
    endfunction

endpackage

// File: rtl/demux_1xn_stream_if.sv
// rtl/demux_1xn_stream_if.sv - input stream, N output streams and error flag of the demux
interface demux_1xn_stream_if #(
    parameter int WIDTH = 8,
    parameter int N     = 4
);
    localparam int SELW = $clog2(N);

    logic [WIDTH-1:0]   in_data;
    logic               in_valid;
    logic               in_last;
    logic [SELW-1:0]    in_sel;
    logic               in_ready;
    logic [N*WIDTH-1:0] out_data;
    logic [N-1:0]       out_valid;
    logic [N-1:0]       out_last;
    logic [N-1:0]       out_ready;
    logic               err_clr;
    logic               err;

    modport slave (
        input  in_data, in_valid, in_last, in_sel, out_ready, err_clr,
        output in_ready, out_data, out_valid, out_last, err
    );

    modport master (
        output in_data, in_valid, in_last, in_sel, out_ready, err_clr,
        input  in_ready, out_data, out_valid, out_last, err
    );

endinterface

// File: rtl/demux_defs.vh
// rtl/demux_defs.vh - FSM state encodings shared across the demux files
`ifndef DEMUX_DEFS_VH
`define DEMUX_DEFS_VH

localparam logic [1:0] ST_IDLE  = 2'd0;
localparam logic [1:0] ST_ROUTE = 2'd1;
localparam logic [1:0] ST_DROP  = 2'd2;

`endif

// File: rtl/demux_out_slot.sv
// rtl/demux_out_slot.sv - one-entry output register; a load in the drain cycle wins
module demux_out_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             ld_last,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             last
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic             last_q;

    // Draining without a reload zeroes the slot so idle channels show 0 data.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= ld_data;
            last_q  <= ld_last;
        end else if (valid_q && ready) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign last  = last_q;

endmodule

// File: rtl/demux_1xn_stream.sv
// rtl/demux_1xn_stream.sv - 1-to-N packet demux: channel chosen on the first beat, locked until last
module demux_1xn_stream
    import demux_1xn_stream_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int N     = 4,
    localparam int SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    demux_1xn_stream_if.slave  bus
);

    demux_state_e     state_q, state_d;
    logic [SELW-1:0]  lock_q, lock_d;
    logic             err_q, err_d;

    logic [SELW-1:0]  ch;
    logic             sel_bad;
    logic             discard;
    logic             in_ready;
    logic             accept;
    logic [N-1:0]     load;
    logic [N-1:0]     slot_valid;
    logic [N-1:0]     slot_last;
    logic [WIDTH-1:0] slot_data [N];
    logic [N*WIDTH-1:0] data_flat;

    assign ch      = (state_q == IDLE) ? bus.in_sel : lock_q;
    assign sel_bad = (state_q == IDLE) && !sel_in_range(int'(bus.in_sel), N);
    assign discard = (state_q == DROP) || sel_bad;

    // Discarded beats never wait; ch is only used as an index once it is known to be in range.
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            if (discard) begin
                in_ready = 1'b1;
            end else begin
                in_ready = !slot_valid[ch] || bus.out_ready[ch];
            end
        end
    end

    assign accept = bus.in_valid && in_ready;

    always_comb begin
        load = '0;
        for (int k = 0; k < N; k++) begin
            load[k] = accept && !discard && (ch == SELW'(k));
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_slot
        demux_out_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .load    (load[k]),
            .ld_data (bus.in_data),
            .ld_last (bus.in_last),
            .ready   (bus.out_ready[k]),
            .valid   (slot_valid[k]),
            .data    (slot_data[k]),
            .last    (slot_last[k])
        );
    end

    always_comb begin
        data_flat = '0;
        for (int k = 0; k < N; k++) begin
            data_flat[k*WIDTH +: WIDTH] = slot_data[k];
        end
    end

    // err_clr is applied first so a same-cycle error still sets the flag.
    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        err_d   = err_q;
        if (bus.err_clr) begin
            err_d = 1'b0;
        end
        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (sel_bad) begin
                        err_d = 1'b1;
                        if (!bus.in_last) begin
                            state_d = DROP;
                        end
                    end else if (!bus.in_last) begin
                        state_d = ROUTE;
                        lock_d  = bus.in_sel;
                    end
                end
                ROUTE, DROP: begin
                    if (bus.in_last) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lock_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = slot_valid;
    assign bus.out_last  = slot_last;
    assign bus.out_data  = data_flat;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_demux_1xn_stream.sv
// tb/tb_demux_1xn_stream.sv - randomized and directed bench for demux_1xn_stream (N=4 and N=3)
module tb_demux_1xn_stream;

    localparam int W  = 8;
    localparam int N4 = 4;
    localparam int N3 = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    demux_1xn_stream_if #(.WIDTH(W), .N(N4)) b4();
    demux_1xn_stream_if #(.WIDTH(W), .N(N3)) b3();

    demux_1xn_stream #(.WIDTH(W), .N(N4)) dut4 (.clk(clk), .rst(rst), .bus(b4));
    demux_1xn_stream #(.WIDTH(W), .N(N3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

    int checks = 0;
    int errors = 0;

    int         rdy_mode  = 0;
    logic [3:0] rdy_fixed = 4'b1111;
    logic [3:0] rdy_dyn   = 4'b1111;
    assign b4.out_ready = (rdy_mode == 0) ? rdy_fixed : rdy_dyn;

    always @(posedge clk) begin
        #1;
        if (rdy_mode == 1) begin
            rdy_dyn = {~rdy_dyn[3], 3'b111};
        end else begin
            for (int k = 0; k < N4; k++) rdy_dyn[k] = ($urandom_range(0, 9) < 7);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference model: one queue per channel standing in for its output slot,
    // plus packet mode (0 idle, 1 routing, 2 dropping) and the locked channel.
    logic [8:0] mq [N4][$];
    int         m_mode = 0;
    int         m_lock = 0;
    logic       m_err  = 1'b0;

    always @(negedge clk) begin
        logic [3:0]  ev, el;
        logic [31:0] ed;
        logic        er, acc, newerr;
        int          tgt;
        ev = '0; el = '0; ed = '0;
        for (int k = 0; k < N4; k++) begin
            if (mq[k].size() > 0) begin
                ev[k] = 1'b1;
                el[k] = mq[k][0][8];
                ed[k*8 +: 8] = mq[k][0][7:0];
            end
        end
        tgt = (m_mode == 0) ? int'(b4.in_sel) : m_lock;
        if (rst) er = 1'b0;
        else if (m_mode == 2) er = 1'b1;
        else if (tgt >= N4) er = 1'b1;
        else er = (mq[tgt].size() == 0) || b4.out_ready[tgt];

        chk("model_out_valid", 32'(b4.out_valid), 32'(ev));
        chk("model_out_last", 32'(b4.out_last), 32'(el));
        chk("model_out_data", b4.out_data, ed);
        chk("model_in_ready", 32'(b4.in_ready), 32'(er));
        chk("model_err", 32'(b4.err), 32'(m_err));

        if (rst) begin
            for (int k = 0; k < N4; k++) mq[k].delete();
            m_mode = 0;
            m_lock = 0;
            m_err  = 1'b0;
        end else begin
            acc    = b4.in_valid && er;
            newerr = 1'b0;
            for (int k = 0; k < N4; k++) begin
                if (mq[k].size() > 0 && b4.out_ready[k]) void'(mq[k].pop_front());
            end
            if (acc) begin
                if (m_mode == 0) begin
                    if (tgt >= N4) begin
                        newerr = 1'b1;
                        m_mode = b4.in_last ? 0 : 2;
                    end else begin
                        mq[tgt].push_back({b4.in_last, b4.in_data});
                        if (!b4.in_last) begin
                            m_mode = 1;
                            m_lock = tgt;
                        end
                    end
                end else if (m_mode == 1) begin
                    mq[m_lock].push_back({b4.in_last, b4.in_data});
                    if (b4.in_last) m_mode = 0;
                end else if (b4.in_last) begin
                    m_mode = 0;
                end
            end
            if (b4.err_clr) m_err = 1'b0;
            if (newerr) m_err = 1'b1;
        end
    end

    logic [8:0] rx [$];
    logic       rx_en = 1'b0;
    always @(negedge clk) begin
        if (rx_en && b4.out_valid[3] && b4.out_ready[3]) rx.push_back({b4.out_last[3], b4.out_data[31:24]});
    end

    task automatic send4(input logic [7:0] d, input logic l, input logic [1:0] s, output int stalls);
        b4.in_data = d; b4.in_last = l; b4.in_sel = s; b4.in_valid = 1'b1;
        stalls = 0;
        forever begin
            @(negedge clk);
            if (b4.in_ready) break;
            stalls++;
            if (stalls > 60) begin
                checks++; errors++;
                $display("FAIL send4_timeout actual=stalled required=accept t=%0t", $time);
                break;
            end
        end
        @(posedge clk);
        #2;
        b4.in_valid = 1'b0;
    endtask

    task automatic send3(input logic [7:0] d, input logic l, input logic [1:0] s, output int stalls);
        b3.in_data = d; b3.in_last = l; b3.in_sel = s; b3.in_valid = 1'b1;
        stalls = 0;
        forever begin
            @(negedge clk);
            if (b3.in_ready) break;
            stalls++;
            if (stalls > 60) begin
                checks++; errors++;
                $display("FAIL send3_timeout actual=stalled required=accept t=%0t", $time);
                break;
            end
        end
        @(posedge clk);
        #2;
        b3.in_valid = 1'b0;
    endtask

    initial begin
        int st;
        int len;
        rst = 1'b1;
        b4.in_data = '0; b4.in_valid = 1'b0; b4.in_last = 1'b0; b4.in_sel = '0; b4.err_clr = 1'b0;
        b3.in_data = '0; b3.in_valid = 1'b0; b3.in_last = 1'b0; b3.in_sel = '0; b3.err_clr = 1'b0;
        b3.out_ready = 3'b111;

        // reset
        tick(); tick();
        chk("rst_in_ready", 32'(b4.in_ready), 32'd0);
        chk("rst_out_valid", 32'(b4.out_valid), 32'd0);
        chk("rst_out_data", b4.out_data, 32'd0);
        chk("rst_out_last", 32'(b4.out_last), 32'd0);
        chk("rst_err3", 32'(b3.err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(b4.in_ready), 32'd1);
        tick();

        // 3-beat packet to ch2, sel changes ignored after first beat
        send4(8'hA1, 1'b0, 2'd2, st);
        chk("p1_b1_valid", 32'(b4.out_valid), 32'h4);
        chk("p1_b1_data", b4.out_data, 32'h00A1_0000);
        chk("p1_b1_last", 32'(b4.out_last), 32'h0);
        send4(8'hA2, 1'b0, 2'd0, st);
        chk("p1_b2_data", b4.out_data, 32'h00A2_0000);
        chk("p1_b2_stall", 32'(st), 32'd0);
        send4(8'hA3, 1'b1, 2'd0, st);
        chk("p1_b3_data", b4.out_data, 32'h00A3_0000);
        chk("p1_b3_last", 32'(b4.out_last), 32'h4);
        tick();
        chk("p1_drained_valid", 32'(b4.out_valid), 32'h0);
        chk("p1_drained_data", b4.out_data, 32'h0);

        // backpressure on ch1 does not block ch3
        rdy_fixed = 4'b1101;
        send4(8'h11, 1'b1, 2'd1, st);
        tick(); tick();
        chk("bp_hold_valid", 32'(b4.out_valid), 32'h2);
        chk("bp_hold_data", b4.out_data, 32'h0000_1100);
        b4.in_data = 8'h22; b4.in_last = 1'b1; b4.in_sel = 2'd1; b4.in_valid = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_low", 32'(b4.in_ready), 32'd0);
        tick();
        @(negedge clk);
        chk("bp_in_ready_low2", 32'(b4.in_ready), 32'd0);
        @(posedge clk); #2;
        rdy_fixed = 4'b1111;
        send4(8'h22, 1'b1, 2'd1, st);
        chk("bp_release_stall", 32'(st), 32'd0);
        rdy_fixed = 4'b1101;
        chk("bp_22_data", b4.out_data, 32'h0000_2200);
        send4(8'h33, 1'b1, 2'd3, st);
        chk("bp_33_stall", 32'(st), 32'd0);
        chk("bp_33_valid", 32'(b4.out_valid), 32'hA);
        chk("bp_33_data", b4.out_data, 32'h3300_2200);
        rdy_fixed = 4'b1111;
        tick();
        chk("bp_drained", 32'(b4.out_valid), 32'h0);

        // N=3: out-of-range select drops the packet and sets sticky err
        send3(8'hE1, 1'b0, 2'd3, st);
        chk("n3_b1_stall", 32'(st), 32'd0);
        chk("n3_b1_valid", 32'(b3.out_valid), 32'd0);
        chk("n3_err_set", 32'(b3.err), 32'd1);
        send3(8'hE2, 1'b1, 2'd0, st);
        chk("n3_b2_stall", 32'(st), 32'd0);
        chk("n3_b2_valid", 32'(b3.out_valid), 32'd0);
        tick(); tick(); tick();
        chk("n3_err_sticky", 32'(b3.err), 32'd1);
        chk("n3_no_valid", 32'(b3.out_valid), 32'd0);
        b3.err_clr = 1'b1;
        tick();
        b3.err_clr = 1'b0;
        chk("n3_err_clr", 32'(b3.err), 32'd0);
        b3.err_clr = 1'b1;
        send3(8'h77, 1'b1, 2'd3, st);
        b3.err_clr = 1'b0;
        chk("n3_set_wins", 32'(b3.err), 32'd1);
        send3(8'h5A, 1'b1, 2'd2, st);
        chk("n3_after_drop_valid", 32'(b3.out_valid), 32'h4);
        chk("n3_after_drop_data", 32'(b3.out_data), 32'h5A_0000);

        // reset in the middle of a packet
        send4(8'hC1, 1'b0, 2'd0, st);
        send4(8'hC2, 1'b0, 2'd0, st);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", 32'(b4.out_valid), 32'h0);
        chk("mid_rst_data", b4.out_data, 32'h0);
        send4(8'h55, 1'b1, 2'd1, st);
        chk("mid_rst_next_valid", 32'(b4.out_valid), 32'h2);
        chk("mid_rst_next_data", b4.out_data, 32'h0000_5500);
        tick();

        // 16-beat stream to ch3 under toggling ready
        rdy_mode = 1;
        rx_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send4(8'(8'h30 + i), (i == 15), (i == 0) ? 2'd3 : 2'($urandom_range(0, 3)), st);
        end
        for (int i = 0; i < 6; i++) tick();
        rx_en = 1'b0;
        rdy_mode = 0;
        chk("stream_count", 32'(rx.size()), 32'd16);
        for (int i = 0; i < 16 && i < rx.size(); i++) begin
            chk("stream_beat", 32'(rx[i]), 32'({(i == 15), 8'(8'h30 + i)}));
        end

        // randomized packets checked every cycle by the model
        rdy_mode = 2;
        for (int p = 0; p < 200; p++) begin
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) begin
                repeat ($urandom_range(0, 2)) tick();
                send4(8'($urandom), (b == len - 1), 2'($urandom_range(0, 3)), st);
            end
        end
        rdy_mode = 0;
        rdy_fixed = 4'b1111;
        tick(); tick(); tick();
        chk("final_drained", 32'(b4.out_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
